// File: rtl/i2c_master_pkg.sv
// Shared I2C master definitions: SDA FSM state codes, counter widths and
// default timing parameters used by scl_timing_gen and sda_generate.
package i2c_master_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int unsigned DEF_THRESHOLD       = 2;
  localparam int unsigned DEF_ADDR_LEN        = 7;
  localparam int unsigned DEF_DATA_LEN        = 8;
  localparam int unsigned DEF_SETUP_SDA_START = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE            = 4'd0,
    ST_READY           = 4'd1,
    ST_SEND_ADDRESS    = 4'd2,
    ST_WRITE_DATA      = 4'd3,
    ST_OUTPUT_DATA     = 4'd4,
    ST_CHECK_ACK       = 4'd5,
    ST_READ_DATA       = 4'd6,
    ST_STORE_DATA      = 4'd7,
    ST_CHECK_FOR_VALID = 4'd8,
    ST_SEND_ACK        = 4'd9,
    ST_SEND_NACK       = 4'd10,
    ST_STOP            = 4'd11
  } state_e;

  // States in which SCL toggles once per bit slot
  function automatic logic is_active(input logic [STATE_W-1:0] st);
    return (st >= ST_SEND_ADDRESS) && (st <= ST_SEND_NACK);
  endfunction

endpackage

// File: rtl/scl_timing_gen_if.sv
// SDA FSM <-> SCL timing generator signal bundle. The master modport is the
// SDA FSM side; the slave modport is the timing generator.
interface scl_timing_gen_if;

  logic                                   rst_count;
  logic [i2c_master_pkg::STATE_W-1:0]     state_master;
  logic                                   scl;
  logic [i2c_master_pkg::CNT_W-1:0]       count_ctrl;
  logic                                   wait_for_sync;
  logic                                   add_sent;
  logic                                   data_sent;
  logic                                   data_received;

  modport master (
    output rst_count, state_master,
    input  scl, count_ctrl, wait_for_sync, add_sent, data_sent, data_received
  );

  modport slave (
    input  rst_count, state_master,
    output scl, count_ctrl, wait_for_sync, add_sent, data_sent, data_received
  );

endinterface

// File: rtl/i2c_scl_phase.sv
// Bit-slot phase counter and registered SCL decode. SCL is low for the first
// THRESHOLD phases of each slot and high for the rest; Stop uses the count.
module i2c_scl_phase
  import i2c_master_pkg::*;
#(
  parameter int unsigned THRESHOLD = DEF_THRESHOLD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STATE_W-1:0] state_i,
  input  logic [CNT_W-1:0]   count_nxt_i,
  output logic               scl_o
);

  localparam int unsigned PERIOD        = 2 * THRESHOLD;
  localparam int unsigned PHASE_W       = $clog2(PERIOD);
  localparam int unsigned STOP_HIGH_CNT = 2 * THRESHOLD;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PERIOD - 1);
  localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(THRESHOLD);

  logic [PHASE_W-1:0] phase_q, phase_d, phase_cur;
  logic [STATE_W-1:0] prev_state_q;
  logic               scl_q, scl_d;
  logic               restart;

  // The first Send_Address cycle after Ready starts a fresh slot at phase 0
  always_comb begin
    restart   = (state_i == ST_SEND_ADDRESS) && (prev_state_q == ST_READY);
    phase_cur = restart ? '0 : phase_q;
    phase_d   = phase_q;
    scl_d     = 1'b1;
    if (is_active(state_i)) begin
      phase_d = (phase_cur == PHASE_LAST) ? '0 : phase_cur + PHASE_W'(1);
      scl_d   = (phase_cur >= PHASE_HIGH);
    end else if (state_i == ST_STOP) begin
      // Look ahead at the next count so SCL lines up with count_ctrl
      scl_d = (32'(count_nxt_i) >= STOP_HIGH_CNT);
    end else if (state_i > ST_STOP) begin
      phase_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= '0;
      scl_q        <= 1'b1;
      prev_state_q <= ST_IDLE;
    end else begin
      phase_q      <= phase_d;
      scl_q        <= scl_d;
      prev_state_q <= state_i;
    end
  end

  assign scl_o = scl_q;

endmodule

// File: rtl/scl_timing_gen.sv
// SCL timing generator: bit-progress counter for the SDA FSM, one-cycle
// progress pulses, and the SCL waveform from the phase sub-module.
module scl_timing_gen
  import i2c_master_pkg::*;
#(
  parameter int unsigned THRESHOLD       = DEF_THRESHOLD,
  parameter int unsigned ADDR_LEN        = DEF_ADDR_LEN,
  parameter int unsigned DATA_LEN        = DEF_DATA_LEN,
  parameter int unsigned SETUP_SDA_START = DEF_SETUP_SDA_START
) (
  input  logic              clk,
  input  logic              rst_n,
  scl_timing_gen_if.slave   bus
);

  localparam int unsigned SLOT = 2 * THRESHOLD;
  localparam logic [CNT_W-1:0] SYNC_CNT      = CNT_W'(SETUP_SDA_START + THRESHOLD);
  localparam logic [CNT_W-1:0] ADDR_DONE_CNT = CNT_W'(ADDR_LEN * SLOT - 1);
  localparam logic [CNT_W-1:0] DATA_DONE_CNT = CNT_W'(DATA_LEN * SLOT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             live;
  logic             scl;

  always_comb begin
    count_d = count_q;
    if (bus.rst_count) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end
    // A count parked at max must not re-fire a pulse decoded at max
    sat_d = (count_q == CNT_MAX) && !bus.rst_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  i2c_scl_phase #(
    .THRESHOLD (THRESHOLD)
  ) u_phase (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_i     (bus.state_master),
    .count_nxt_i (count_d),
    .scl_o       (scl)
  );

  assign live = rst_n && !sat_q;

  assign bus.scl           = scl;
  assign bus.count_ctrl    = count_q;
  assign bus.wait_for_sync = live && (bus.state_master == ST_READY)
                                  && (count_q == SYNC_CNT);
  assign bus.add_sent      = live && (bus.state_master == ST_SEND_ADDRESS)
                                  && (count_q == ADDR_DONE_CNT);
  assign bus.data_sent     = live && (bus.state_master == ST_OUTPUT_DATA)
                                  && (count_q == DATA_DONE_CNT);
  assign bus.data_received = live && (bus.state_master == ST_STORE_DATA)
                                  && (count_q == DATA_DONE_CNT);

endmodule

// File: tb/tb_scl_timing_gen.sv
// Directed self-checking bench for scl_timing_gen with default parameters
// (THRESHOLD=2, ADDR_LEN=7, DATA_LEN=8, SETUP_SDA_START=2).
module tb_scl_timing_gen;
  import i2c_master_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  scl_timing_gen_if bus();

  scl_timing_gen #(
    .THRESHOLD       (2),
    .ADDR_LEN        (7),
    .DATA_LEN        (8),
    .SETUP_SDA_START (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [3:0] st, input logic rc);
    bus.state_master = st;
    bus.rst_count    = rc;
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] pulses;
    rst_n = 1'b0;
    set_in(ST_IDLE, 1'b0);
    #20;
    pulses = {bus.wait_for_sync, bus.add_sent, bus.data_sent, bus.data_received};
    n_checks++;
    if (bus.scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b expected 1", bus.scl); end
    n_checks++;
    if (bus.count_ctrl !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count_ctrl); end
    n_checks++;
    if (pulses !== 4'b0000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", pulses); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.count_ctrl !== 7'd1) begin n_fail++; $display("FAIL release_count: got %0d expected 1", bus.count_ctrl); end
  endtask

  task automatic test_ready();
    set_in(ST_READY, 1'b1);
    tick();
    set_in(ST_READY, 1'b0);
    for (int c = 0; c < 9; c++) begin
      logic exp_p;
      exp_p = (c == 4);
      n_checks++;
      if (bus.count_ctrl !== 7'(c)) begin n_fail++; $display("FAIL ready_count: got %0d expected %0d", bus.count_ctrl, c); end
      n_checks++;
      if (bus.scl !== 1'b1) begin n_fail++; $display("FAIL ready_scl at count %0d: got %b expected 1", c, bus.scl); end
      n_checks++;
      if (bus.wait_for_sync !== exp_p) begin n_fail++; $display("FAIL ready_wait_for_sync at count %0d: got %b expected %b", c, bus.wait_for_sync, exp_p); end
      tick();
    end
  endtask

  // Send_Address from count 0, then a mid-slot move to Write_Data at count 31
  task automatic test_send_address();
    set_in(ST_READY, 1'b1);
    tick();
    set_in(ST_SEND_ADDRESS, 1'b0);
    for (int c = 0; c < 39; c++) begin
      logic exp_scl, exp_p;
      if (c == 31) set_in(ST_WRITE_DATA, 1'b0);
      exp_scl = (c == 0) ? 1'b1 : ((((c - 1) % 4) < 2) ? 1'b0 : 1'b1);
      exp_p   = (c == 27);
      n_checks++;
      if (bus.count_ctrl !== 7'(c)) begin n_fail++; $display("FAIL addr_count: got %0d expected %0d", bus.count_ctrl, c); end
      n_checks++;
      if (bus.scl !== exp_scl) begin n_fail++; $display("FAIL addr_scl at count %0d: got %b expected %b", c, bus.scl, exp_scl); end
      n_checks++;
      if (bus.add_sent !== exp_p) begin n_fail++; $display("FAIL add_sent at count %0d: got %b expected %b", c, bus.add_sent, exp_p); end
      tick();
    end
  endtask

  task automatic test_output_data();
    set_in(ST_OUTPUT_DATA, 1'b1);
    tick();
    set_in(ST_OUTPUT_DATA, 1'b0);
    for (int c = 0; c < 200; c++) begin
      int   exp_cnt;
      logic exp_p;
      exp_cnt = (c > 127) ? 127 : c;
      exp_p   = (c == 31);
      n_checks++;
      if (bus.count_ctrl !== 7'(exp_cnt)) begin n_fail++; $display("FAIL od_count at cycle %0d: got %0d expected %0d", c, bus.count_ctrl, exp_cnt); end
      n_checks++;
      if (bus.data_sent !== exp_p) begin n_fail++; $display("FAIL data_sent at cycle %0d: got %b expected %b", c, bus.data_sent, exp_p); end
      tick();
    end
  endtask

  task automatic test_store_clear();
    set_in(ST_STORE_DATA, 1'b1);
    tick();
    set_in(ST_STORE_DATA, 1'b0);
    for (int c = 0; c < 31; c++) begin
      n_checks++;
      if (bus.data_received !== 1'b0) begin n_fail++; $display("FAIL data_received_early at count %0d: got %b expected 0", c, bus.data_received); end
      tick();
    end
    n_checks++;
    if (bus.count_ctrl !== 7'd31) begin n_fail++; $display("FAIL store_count: got %0d expected 31", bus.count_ctrl); end
    set_in(ST_STORE_DATA, 1'b1);
    n_checks++;
    if (bus.data_received !== 1'b1) begin n_fail++; $display("FAIL data_received_with_clear: got %b expected 1", bus.data_received); end
    tick();
    set_in(ST_STORE_DATA, 1'b0);
    n_checks++;
    if (bus.count_ctrl !== 7'd0) begin n_fail++; $display("FAIL store_cleared_count: got %0d expected 0", bus.count_ctrl); end
    n_checks++;
    if (bus.data_received !== 1'b0) begin n_fail++; $display("FAIL data_received_after_clear: got %b expected 0", bus.data_received); end
  endtask

  task automatic test_stop_idle();
    set_in(ST_STOP, 1'b1);
    tick();
    set_in(ST_STOP, 1'b0);
    for (int c = 0; c < 10; c++) begin
      logic exp_scl;
      exp_scl = (c >= 4);
      n_checks++;
      if (bus.count_ctrl !== 7'(c)) begin n_fail++; $display("FAIL stop_count: got %0d expected %0d", bus.count_ctrl, c); end
      n_checks++;
      if (bus.scl !== exp_scl) begin n_fail++; $display("FAIL stop_scl at count %0d: got %b expected %b", c, bus.scl, exp_scl); end
      tick();
    end
    set_in(ST_IDLE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.scl !== 1'b1) begin n_fail++; $display("FAIL idle_scl: got %b expected 1", bus.scl); end
    end
  endtask

  task automatic test_unlisted();
    set_in(4'd13, 1'b1);
    tick();
    set_in(4'd13, 1'b0);
    for (int c = 0; c < 36; c++) begin
      logic [3:0] pulses;
      pulses = {bus.wait_for_sync, bus.add_sent, bus.data_sent, bus.data_received};
      n_checks++;
      if (bus.scl !== 1'b1) begin n_fail++; $display("FAIL unlisted_scl at count %0d: got %b expected 1", c, bus.scl); end
      n_checks++;
      if (pulses !== 4'b0000) begin n_fail++; $display("FAIL unlisted_pulses at count %0d: got %b expected 0000", c, pulses); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] pulses;
    set_in(ST_OUTPUT_DATA, 1'b1);
    tick();
    set_in(ST_OUTPUT_DATA, 1'b0);
    repeat (10) tick();
    n_checks++;
    if (bus.count_ctrl !== 7'd10) begin n_fail++; $display("FAIL mid_count: got %0d expected 10", bus.count_ctrl); end
    rst_n = 1'b0;
    #1;
    pulses = {bus.wait_for_sync, bus.add_sent, bus.data_sent, bus.data_received};
    n_checks++;
    if (bus.scl !== 1'b1) begin n_fail++; $display("FAIL mid_reset_scl: got %b expected 1", bus.scl); end
    n_checks++;
    if (bus.count_ctrl !== 7'd0) begin n_fail++; $display("FAIL mid_reset_count: got %0d expected 0", bus.count_ctrl); end
    n_checks++;
    if (pulses !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_pulses: got %b expected 0000", pulses); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.count_ctrl !== 7'd1) begin n_fail++; $display("FAIL mid_release_count: got %0d expected 1", bus.count_ctrl); end
  endtask

  initial begin
    test_reset();
    test_ready();
    test_send_address();
    test_output_data();
    test_store_clear();
    test_stop_idle();
    test_unlisted();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
